apb_mem_slave: RTL

Parametrised APB4 memory-mapped slave, the next generation of the team's two-slave APB memory targets. Provides a DEPTH-word register file with configurable data/address width, programmable wait states, byte strobes and an error response for out-of-range addresses. Sits behind the APB bridge's per-slave PSEL decode, one instance per slave slot.

---
 rtl/apb_mem_slave_if.sv | 30 +++
 rtl/apb_mem_slave.sv | 128 ++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if: APB4 completer-side signal bundle for one slave slot.
// Ports (per modport):
//   master - drives PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB; receives PRDATA, PREADY, PSLVERR
//   slave  - receives the request signals; drives PRDATA, PREADY, PSLVERR
interface apb_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 word-addressed register-file slave with programmable
// wait states, byte strobes and an error response for out-of-range words.
// Ports:
//   PCLK   - clock, all state changes on the rising edge
//   PRESET - asynchronous active-high reset (control state and outputs only)
//   apb    - APB slave bundle (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in,
//            PRDATA/PREADY/PSLVERR out); PREADY/PSLVERR/PRDATA are flops
module apb_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_mem_slave_if.slave apb
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WIDTH   = 4;
  localparam int unsigned LIMIT_WIDTH = ADDR_WIDTH + 1;

  localparam logic [LIMIT_WIDTH-1:0] DEPTH_LIMIT = LIMIT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]   CNT_LOAD    = CNT_WIDTH'(WAIT_STATES);
  localparam logic                   LOAD_READY  = (WAIT_STATES == 0);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [IDX_WIDTH-1:0]  r_addr_q;
  logic                  r_write_q;
  logic                  r_err_q;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_access;
  logic                  w_in_range;
  logic                  w_done;
  logic [IDX_WIDTH-1:0]  w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_setup    = apb.PSEL & ~apb.PENABLE;
  assign w_access   = apb.PSEL & apb.PENABLE;
  // Extra MSB lets DEPTH == 2**ADDR_WIDTH compare correctly.
  assign w_in_range = ({1'b0, apb.PADDR} < DEPTH_LIMIT);
  assign w_rd_idx   = IDX_WIDTH'(apb.PADDR);
  assign w_rd_word  = r_mem[w_rd_idx];
  assign w_done     = (r_state == S_ACCESS) & w_access & (r_cnt == '0);

  // Control FSM; PREADY/PSLVERR are precomputed one edge ahead so they
  // equal (ACCESS & cnt==0) and (that & err) purely from flops.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr_q  <= '0;
      r_write_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_state   <= S_ACCESS;
            r_addr_q  <= w_rd_idx;
            r_write_q <= apb.PWRITE;
            r_err_q   <= ~w_in_range;
            r_cnt     <= CNT_LOAD;
            r_pready  <= LOAD_READY;
            r_pslverr <= LOAD_READY & ~w_in_range;
            // Read data is captured at setup so it is stable for the whole access.
            if (!apb.PWRITE) begin
              r_prdata <= w_in_range ? w_rd_word : '0;
            end
          end
        end
        S_ACCESS: begin
          if (!w_access) begin
            // Protocol abort: drop the transfer without completion.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt     <= r_cnt - CNT_WIDTH'(1);
            r_pready  <= (r_cnt == CNT_WIDTH'(1));
            r_pslverr <= (r_cnt == CNT_WIDTH'(1)) & r_err_q;
          end else begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; not reset. Commits strobed lanes at the completion edge.
  always_ff @(posedge PCLK) begin
    if (w_done && r_write_q && !r_err_q) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (apb.PSTRB[b]) begin
          r_mem[r_addr_q][8*b +: 8] <= apb.PWDATA[8*b +: 8];
        end
      end
    end
  end

  assign apb.PRDATA  = r_prdata;
  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;

endmodule
